// File: rtl/seq_divider_16_if.sv
// seq_divider_16_if: start/ready/done handshake plus operand and result bus
// for the sequential divider.
interface seq_divider_16_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_16.sv
// seq_divider_16: unsigned restoring divider, one quotient bit per cycle,
// with a start/ready/done handshake.
module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    seq_divider_16_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] prem_q, qreg_q, dvs_q, quo_q, rem_q;
    logic             dbz_q;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] prem_d, qreg_d;
    logic             accept, last;

    assign accept = (state_q == IDLE) && bus.start;
    assign last   = cnt_q == CW'(WIDTH - 1);

    // Trial subtraction keeps the extra bit so its MSB is the borrow.
    always_comb begin
        shifted = {prem_q, qreg_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        prem_d  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        qreg_d  = {qreg_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = !bus.start ? IDLE : (bus.divisor == '0 ? DONE : RUN);
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = state_q == IDLE;
        bus.done  = state_q == DONE;
    end

    // Result registers change only when an operation enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            prem_q <= '0;
            qreg_q <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            prem_q <= '0;
            qreg_q <= bus.dividend;
            dvs_q  <= bus.divisor;
            dbz_q  <= bus.divisor == '0;
            if (bus.divisor == '0) begin
                quo_q <= '1;
                rem_q <= bus.dividend;
            end
        end else if (state_q == RUN) begin
            cnt_q  <= cnt_q + CW'(1);
            prem_q <= prem_d;
            qreg_q <= qreg_d;
            if (last) begin
                quo_q <= qreg_d;
                rem_q <= prem_d;
            end
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_16.sv
// tb_seq_divider_16: scoreboard-driven checks of the sequential divider.
module tb_seq_divider_16;
    localparam int SOAK = 2000;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    seq_divider_16_if #(.WIDTH(16)) bus ();

    seq_divider_16 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Drives one start from IDLE and returns at the negedge after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        e.q = (b == 0) ? 16'hFFFF : a / b;
        e.r = (b == 0) ? a : a % b;
        e.z = (b == 0);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        #1;
        checks++;
        if ({bus.ready, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 33'd0})
            $display("FAIL reset_state: got %h expected %h",
                     {bus.ready, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, {1'b1, 1'b0, 33'd0});
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        exp_t e;
        int n;
        issue(16'd100, 16'd7);
        wait_done(n);
        checks++;
        if (n + 1 !== 17) $display("FAIL basic_latency: got %0d expected 17", n + 1);
        else passes++;
        e = sb.pop_front();
        checks++;
        if ({bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 16'd14, 16'd2, 1'b0})
            $display("FAIL basic_result: got %h expected %h",
                     {bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, {1'b1, e});
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.done, bus.ready} !== 2'b01) $display("FAIL basic_done_pulse: got %b expected 01", {bus.done, bus.ready});
        else passes++;
    endtask

    task automatic test_boundaries();
        logic [15:0] tab [3][2] = '{'{16'hFFFF, 16'd1}, '{16'hFFFF, 16'hFFFF}, '{16'd3, 16'd10}};
        exp_t e;
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(tab[i][0], tab[i][1]);
            wait_done(n);
            e = sb.pop_front();
            checks++;
            if ({bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, e})
                $display("FAIL boundary_%0d: got %h expected %h", i,
                         {bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, {1'b1, e});
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        int n;
        issue(16'd5, 16'd0);
        wait_done(n);
        checks++;
        if (n !== 0) $display("FAIL dbz_latency: got %0d expected 1", n + 1);
        else passes++;
        e = sb.pop_front();
        checks++;
        if ({bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 16'hFFFF, 16'd5, 1'b1})
            $display("FAIL dbz_result: got %h expected %h",
                     {bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, {1'b1, e});
        else passes++;
        @(negedge clk);
        issue(16'd20, 16'd4);
        checks++;
        if (bus.div_by_zero !== 1'b0) $display("FAIL dbz_clear_on_start: got %b expected 0", bus.div_by_zero);
        else passes++;
        wait_done(n);
        e = sb.pop_front();
        checks++;
        if ({bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 16'd5, 16'd0, 1'b0})
            $display("FAIL dbz_followup: got %h expected %h",
                     {bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, {1'b1, e});
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int n;
        bit extra = 0;
        issue(16'd1000, 16'd9);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) $display("FAIL ignore_ready_run: got %b expected 0", bus.ready);
        else passes++;
        bus.start = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = 16'd7;
        bus.divisor = 16'd0;
        wait_done(n);
        e = sb.pop_front();
        checks++;
        if ({bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 16'd111, 16'd1, 1'b0})
            $display("FAIL ignore_result: got %h expected %h",
                     {bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, {1'b1, e});
        else passes++;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) $display("FAIL ignore_ready_after: got %b expected 1", bus.ready);
        else passes++;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) extra = 1;
        end
        checks++;
        if ({extra, bus.quotient, bus.remainder} !== {1'b0, 16'd111, 16'd1})
            $display("FAIL ignore_no_extra_op: got %h expected %h", {extra, bus.quotient, bus.remainder}, {1'b0, 16'd111, 16'd1});
        else passes++;
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int n;
        bit seen = 0;
        issue(16'd60000, 16'd13);
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        checks++;
        if ({bus.ready, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 33'd0})
            $display("FAIL abort_state: got %h expected %h",
                     {bus.ready, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, {1'b1, 1'b0, 33'd0});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", seen);
        else passes++;
        issue(16'd60000, 16'd13);
        wait_done(n);
        e = sb.pop_front();
        checks++;
        if ({bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 16'd4615, 16'd5, 1'b0})
            $display("FAIL abort_rerun: got %h expected %h",
                     {bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, {1'b1, e});
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int acc = 0, seen = 0, cyc = 0, last = -1;
        logic [15:0] a, b;
        while (seen < SOAK && cyc < SOAK * 18 + 200) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                e = sb.pop_front();
                checks++;
                if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e)
                    $display("FAIL soak_result_%0d: got %h expected %h", seen,
                             {bus.quotient, bus.remainder, bus.div_by_zero}, e);
                else passes++;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 18) $display("FAIL soak_spacing_%0d: got %0d expected 18", seen, cyc - last);
                    else passes++;
                end
                last = cyc;
                seen++;
            end
            a = 16'($urandom);
            b = 16'($urandom);
            if (b == 0) b = 16'd1;
            bus.dividend = a;
            bus.divisor = b;
            if (bus.ready) begin
                bus.start = acc < SOAK;
                if (acc < SOAK) begin
                    e.q = a / b;
                    e.r = a % b;
                    e.z = 1'b0;
                    sb.push_back(e);
                    acc++;
                end
            end else bus.start = 1'b1;
        end
        bus.start = 1'b0;
        checks++;
        if (seen !== SOAK) $display("FAIL soak_count: got %0d expected %0d", seen, SOAK);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
